pe_mul_share_arbiter: RTL and testbench
=======================================

# pe_mul_share_arbiter

Round-robin arbiter that time-shares one signed DATA_WIDTH x DATA_WIDTH multiplier, truncated to DATA_WIDTH bits, among NUM_REQ requesters inside a processing element of the matrix-multiply array. Each requester issues operand pairs over a valid/ready handshake. Products come back in issue order on one response port, tagged with the requester index, through a PIPE_STAGES-deep register pipeline that stalls under backpressure.

## Interface
- NUM_REQ, 4: number of requesters; 2..8.
- DATA_WIDTH, 16: operand and result width.
- PIPE_STAGES, 2: register stages between issue and response; 1..4.
- ID_W, $clog2(NUM_REQ): width of resp_id.
- ap_clk  in  1  the only clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  NUM_REQ  bit i: requester i holds a valid operand pair.
- req_ready  out  NUM_REQ  bit i: requester i's pair is accepted this cycle.
- req_din0  in  NUM_REQ*DATA_WIDTH  flattened operand A; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_din1  in  NUM_REQ*DATA_WIDTH  flattened operand B, same packing as req_din0.
- resp_valid  out  1  resp_dout and resp_id are valid.
- resp_ready  in  1  downstream accepts the response.
- resp_dout  out  DATA_WIDTH  product.
- resp_id  out  ID_W  index of the requester that issued the product.
- busy  out  1  at least one pipeline stage holds valid data.

## Operation
- Advance enable: en = !resp_valid || resp_ready. When en=1, every stage shifts by one, valid bits included. When en=0, every stage holds. Bubbles are not squeezed out.
- Arbitration is combinational. The search starts at index ptr+1 (mod NUM_REQ) and the first i with req_valid[i]=1 wins.
- req_ready[i] = en && (i == winner) && any req_valid. At most one bit of req_ready is high in any cycle.
- Handshake: a pair is accepted when req_valid[i] && req_ready[i]. On acceptance, ptr takes the winner's index. ptr does not change in any other cycle.
- Requesters hold valid and data stable until they are accepted. The block may drop a requester's claim between cycles if its req_valid falls before acceptance; no other state is affected.
- Arithmetic: product = $signed(din0) * $signed(din1), reduced to its low DATA_WIDTH bits (mod 2^DATA_WIDTH, two's complement). No saturation, no overflow flag.
- The multiply is combinational at issue. Its result and the requester index enter stage 1. The last stage drives resp_*.
- Only the stage valid bits need reset. Data and id registers may be reset-free internally, but resp_dout and resp_id must read 0 after reset.
- Reset values: all stage valid bits = 0, resp_valid=0, resp_dout=0, resp_id=0, busy=0, ptr=NUM_REQ-1 (requester 0 has first priority), req_ready=0 while ap_rst_n=0.
- Reset mid-operation: all in-flight products are discarded and never appear on resp. Arbitration restarts from requester 0.

## Timing
- Latency: a pair accepted at edge t appears with resp_valid=1 after edge t+PIPE_STAGES-1. The response is therefore valid in cycle t+PIPE_STAGES, provided there is no stall.
- Throughput: one issue and one response per cycle while resp_ready=1.
- Each cycle of resp_valid=1 && resp_ready=0 adds one cycle of latency to every in-flight item. During such a cycle req_ready is all-zero and resp_* hold stable.
- Simultaneous response pop and new issue in the same cycle are allowed. Pipeline occupancy stays unchanged.
- Response order equals acceptance order. resp_id always matches the requester that was accepted.
- busy = OR of all stage valid bits, registered-derived; it carries no combinational path from the inputs.

## Test plan
- Reset, then a single requester: req_valid=4'b0100 with din0=3, din1=7, PIPE_STAGES=2, resp_ready=1. Required: req_ready=4'b0100 in the first cycle, and resp_valid=1 with resp_dout=21 and resp_id=2 two cycles later. A second pair must wait until both of these hold:
  - its valid is reasserted;
  - the cycle after the first acceptance has passed.
- Fairness: all four requesters hold valid continuously. Required grant order 0,1,2,3,0,1. Responses carry the ids in that order back to back with no idle cycles.
- Arithmetic edges, each checked at resp_dout:
  - -3 * 7 gives 0xFFEB;
  - 300 * 300 gives 0x5F90 (90000 mod 65536);
  - -32768 * -1 gives 0x8000;
  - 0x7FFF * 0x7FFF gives 0x0001.
- Backpressure: stream from requesters 0 and 1 and hold resp_ready=0 for 5 cycles once resp_valid=1. Required:
  - req_ready stays all-zero during the stall;
  - resp_dout and resp_id stay stable during the stall;
  - no response is lost or duplicated;
  - after release, order and ids remain correct.
- Reset mid-stream: deassert ap_rst_n asynchronously between edges while 2 items are in flight. Required:
  - resp_valid and busy fall to 0 immediately;
  - neither in-flight item appears after reset release;
  - the next grant goes to requester 0 when all requesters are valid.
- Requester withdraws: requester 1 asserts valid while requester 0 is being granted, then drops valid before its turn. Required: the next grant skips it and goes to requester 2 or 3; ptr is unchanged until that acceptance.

Source files
------------

// File: rtl/pe_mul_share_arbiter.sv
// pe_mul_share_arbiter: round-robin sharing of one truncated signed multiplier
// among NUM_REQ requesters, with an in-order stallable response pipeline.
module pe_mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int PIPE_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din1,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_dout,
  output logic [ID_W-1:0]               resp_id,
  output logic                          busy
);
  logic [ID_W-1:0]        ptr_q, ptr_d, win;
  logic                   hit, en, acc;
  logic [DATA_WIDTH-1:0]  a, b;
  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]  dat_q [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  dat_d [PIPE_STAGES];
  logic [ID_W-1:0]        id_q  [PIPE_STAGES];
  logic [ID_W-1:0]        id_d  [PIPE_STAGES];
  assign resp_valid = vld_q[PIPE_STAGES-1];
  assign resp_dout  = dat_q[PIPE_STAGES-1];
  assign resp_id    = id_q[PIPE_STAGES-1];
  assign busy       = |vld_q;
  assign en         = !resp_valid || resp_ready;
  // Scan farthest-first so the nearest valid index after ptr is the last write.
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        win = ID_W'((int'(ptr_q) + k) % NUM_REQ);
        hit = 1'b1;
      end
  end
  assign acc       = en && hit && ap_rst_n;
  assign req_ready = acc ? (NUM_REQ'(1) << win) : '0;
  assign a         = req_din0[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  assign b         = req_din1[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  always_comb begin
    ptr_d = acc ? win : ptr_q;
    vld_d = vld_q;
    dat_d = dat_q;
    id_d  = id_q;
    if (en) begin
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        dat_d[s] = dat_q[s-1];
        id_d[s]  = id_q[s-1];
      end
      vld_d[0] = acc;
      dat_d[0] = DATA_WIDTH'($signed(a) * $signed(b));
      id_d[0]  = win;
    end
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
      vld_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        dat_q[s] <= '0;
        id_q[s]  <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
      id_q  <= id_d;
    end
endmodule

// File: tb/tb_pe_mul_share_arbiter.sv
// tb_pe_mul_share_arbiter: directed and random stimulus against a queue-based
// reference model of the shared-multiplier arbiter.
module tb_pe_mul_share_arbiter;
  localparam int N = 4, W = 16, P = 2, IW = 2;
  logic           ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0, req_ready;
  logic [N*W-1:0] req_din0 = '0, req_din1 = '0;
  logic           resp_valid, resp_ready = 1'b1, busy;
  logic [W-1:0]   resp_dout;
  logic [IW-1:0]  resp_id;
  int checks = 0, passed = 0;
  typedef struct {logic [W-1:0] p; int id; int left;} item_t;
  item_t q[$];
  int ptr = N - 1;
  int dgrants[$];
  logic [W-1:0] dresp[$];
  logic [N-1:0] accepted = '0, last_rdy;
  logic last_rv;
  logic [W-1:0] last_dout;
  logic [IW-1:0] last_id;

  always #5 ap_clk = ~ap_clk;

  pe_mul_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .PIPE_STAGES(P)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_dout(resp_dout), .resp_id(resp_id), .busy(busy));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int winner();
    for (int k = 1; k <= N; k++)
      if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit ev, en;
    int w;
    logic [N-1:0] er;
    int pa, pb;
    @(negedge ap_clk);
    ev = q.size() > 0 && q[0].left == 0;
    en = !ev || resp_ready;
    w  = winner();
    er = (en && w >= 0) ? N'(1) << w : '0;
    chk("req_ready", req_ready, er);
    chk("resp_valid", resp_valid, ev);
    chk("busy", busy, q.size() > 0);
    if (ev) begin
      chk("resp_dout", resp_dout, q[0].p);
      chk("resp_id", resp_id, q[0].id);
    end
    last_rdy = req_ready; last_rv = resp_valid; last_dout = resp_dout; last_id = resp_id;
    for (int i = 0; i < N; i++) if (req_ready[i]) dgrants.push_back(i);
    if (resp_valid && resp_ready) dresp.push_back(resp_dout);
    @(posedge ap_clk);
    if (en) begin
      if (ev) q.pop_front();
      foreach (q[j]) q[j].left--;
      if (w >= 0) begin
        pa = $signed(req_din0[w*W +: W]);
        pb = $signed(req_din1[w*W +: W]);
        q.push_back('{p: W'(pa * pb), id: w, left: P - 1});
        ptr = w;
      end
    end
    accepted = er;
    #1;
  endtask

  task automatic set_pair(int i, int x, int y);
    req_din0[i*W +: W] = W'(x);
    req_din1[i*W +: W] = W'(y);
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++)
      if (accepted[i]) set_pair(i, $urandom, $urandom);
  endtask

  task automatic rand_drive();
    for (int i = 0; i < N; i++)
      if (!req_valid[i] || accepted[i]) begin
        req_valid[i] = $urandom_range(0, 99) < 60;
        set_pair(i, $urandom, $urandom);
      end else if ($urandom_range(0, 99) < 5) req_valid[i] = 1'b0;
    resp_ready = $urandom_range(0, 99) < 75;
  endtask

  task automatic drain();
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 2 * P + 2; i++) step();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst resp_valid", resp_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst resp_dout", resp_dout, 0);
    q.delete();
    ptr = N - 1;
    accepted = '0;
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] hold_d;
    logic [IW-1:0] hold_i;
    int n;
    req_valid = 4'hF;
    #3;
    chk("reset resp_valid", resp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset req_ready", req_ready, 0);
    chk("reset resp_dout", resp_dout, 0);
    chk("reset resp_id", resp_id, 0);
    req_valid = '0;
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    // Single requester 2: 3*7.
    req_valid = 4'b0100;
    set_pair(2, 3, 7);
    step();
    chk("single grant", last_rdy, 4'b0100);
    req_valid = '0;
    step();
    step();
    chk("single resp_valid", last_rv, 1);
    chk("single resp_dout", last_dout, 21);
    chk("single resp_id", last_id, 2);
    drain();

    // Arithmetic edges issued back to back from requester 0.
    dresp.delete();
    req_valid = 4'b0001;
    set_pair(0, -3, 7);          step();
    set_pair(0, 300, 300);       step();
    set_pair(0, -32768, -1);     step();
    set_pair(0, 32767, 32767);   step();
    drain();
    n = dresp.size();
    chk("arith count", n, 4);
    if (n == 4) begin
      chk("arith -3*7", dresp[0], 16'hFFEB);
      chk("arith 300*300", dresp[1], 16'h5F90);
      chk("arith -32768*-1", dresp[2], 16'h8000);
      chk("arith 7fff^2", dresp[3], 16'h0001);
    end

    // Backpressure: stall 5 cycles once a response is showing.
    dresp.delete();
    req_valid = 4'b0011;
    set_pair(0, 5, 6); set_pair(1, -2, 9);
    n = 0;
    while (!last_rv && n < 10) begin step(); refresh(); n++; end
    chk("bp response seen", last_rv, 1);
    resp_ready = 1'b0;
    step(); refresh();
    hold_d = last_dout; hold_i = last_id;
    for (int i = 0; i < 4; i++) begin
      step(); refresh();
      chk("bp stall ready", last_rdy, 0);
      chk("bp stall dout", last_dout, hold_d);
      chk("bp stall id", last_id, hold_i);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin step(); refresh(); end

    // Reset with items in flight, then fairness from requester 0.
    chk("pre-reset busy", busy, 1);
    mid_reset();
    dgrants.delete();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) set_pair(i, i + 1, 10);
    for (int i = 0; i < 6; i++) step();
    n = dgrants.size();
    chk("fair count", n, 6);
    if (n == 6)
      for (int i = 0; i < 6; i++) chk("fair order", dgrants[i], i % N);
    drain();

    // Requester 1 withdraws before its turn.
    dgrants.delete();
    req_valid = 4'b0011;
    step();
    req_valid = 4'b0000;
    step();
    req_valid = 4'b1100;
    step();
    n = dgrants.size();
    chk("withdraw count", n, 2);
    if (n == 2) begin
      chk("withdraw first", dgrants[0], 0);
      chk("withdraw skip", dgrants[1], 2);
    end
    drain();

    // Random traffic with occasional mid-stream resets.
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      if (c % 750 == 749) mid_reset();
      else step();
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
